// File: rtl/concat_stream_sched.sv
// ---------------------------------------------------------------------------
// concat_stream_sched
//
// Shares one shift_concat packer between N_REQ codeword sources. A requester
// is chosen round-robin at message granularity and keeps the grant until its
// last fragment has been packed and the packer has reported the final flush.
// Fragments are forwarded one per strobe, with MIN_GAP idle cycles after each
// strobe, while the pending fill level is tracked modulo 64.
//
// Optional build macro: CONCAT_STATS_EN adds strobe/message counters.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   req_valid      per requester: fragment presented
//   req_data       per requester: 64-bit right-aligned fragment, slice [64i+63:64i]
//   req_bits       per requester: 7-bit valid bit count (0..64 legal)
//   req_last       per requester: fragment closes the message
//   req_ready      per requester: one-cycle accept pulse (granted requester only)
//   sc_data_in     fragment data towards shift_concat
//   sc_valid_bits  fragment bit count towards shift_concat
//   sc_data_valid  one-cycle fragment strobe
//   sc_msg_fin     end-of-message flag, qualified by sc_data_valid
//   sc_done        word-complete / flush-complete pulse from shift_concat
//   grant_id       index of the requester holding the grant
//   busy           high whenever the scheduler is not idle
//   fill_bits      bits pending inside the packer, modulo 64
//   err_len        sticky: a fragment longer than 64 bits was dropped
//   err_timeout    sticky: flush completion did not arrive in time
//   stats_frags    (CONCAT_STATS_EN) strobes issued, wrapping
//   stats_msgs     (CONCAT_STATS_EN) messages completed, wrapping
// ---------------------------------------------------------------------------
module concat_stream_sched #(
   parameter int N_REQ        = 2,
   parameter int MIN_GAP      = 1,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [64*N_REQ-1:0]  req_data,
   input  logic [7*N_REQ-1:0]   req_bits,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [63:0]          sc_data_in,
   output logic [6:0]           sc_valid_bits,
   output logic                 sc_data_valid,
   output logic                 sc_msg_fin,
   input  logic                 sc_done,
   output logic [2:0]           grant_id,
   output logic                 busy,
   output logic [5:0]           fill_bits,
   output logic                 err_len,
   output logic                 err_timeout
`ifdef CONCAT_STATS_EN
   ,
   output logic [31:0]          stats_frags,
   output logic [15:0]          stats_msgs
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP - 1);
   localparam logic [7:0] TO_LAST  = 8'(DONE_TIMEOUT - 1);

   state_t             r_state;
   logic [2:0]         r_ptr;
   logic [2:0]         r_grant;
   logic [5:0]         r_fill;
   logic [3:0]         r_gap_cnt;
   logic [7:0]         r_to_cnt;
   logic               r_last;
   logic               r_fin_sent;
   logic [N_REQ-1:0]   r_ready;
   logic [63:0]        r_data;
   logic [6:0]         r_vb;
   logic               r_dv;
   logic               r_fin;
   logic               r_busy;
   logic               r_err_len;
   logic               r_err_to;
`ifdef CONCAT_STATS_EN
   logic [31:0]        r_stats_frags;
   logic [15:0]        r_stats_msgs;
`endif

   logic               w_found;
   logic [2:0]         w_sel;
   logic               w_g_valid;
   logic [63:0]        w_g_data;
   logic [6:0]         w_g_bits;
   logic               w_g_last;
   logic [N_REQ-1:0]   w_gnt_oh;
   logic [2:0]         w_ptr_nxt;
   logic               w_flush_imm;
   logic               w_flush_end;

   assign req_ready     = r_ready;
   assign sc_data_in    = r_data;
   assign sc_valid_bits = r_vb;
   assign sc_data_valid = r_dv;
   assign sc_msg_fin    = r_fin;
   assign grant_id      = r_grant;
   assign busy          = r_busy;
   assign fill_bits     = r_fill;
   assign err_len       = r_err_len;
   assign err_timeout   = r_err_to;
`ifdef CONCAT_STATS_EN
   assign stats_frags   = r_stats_frags;
   assign stats_msgs    = r_stats_msgs;
`endif

   // Round-robin search: first valid requester at or after the pointer, wrapping.
   always_comb begin
      logic [3:0] v_idx;
      w_found = 1'b0;
      w_sel   = 3'd0;
      v_idx   = 4'd0;
      for (int k = 0; k < N_REQ; k++) begin
         v_idx = {1'b0, r_ptr} + 4'(k);
         if (v_idx >= 4'(N_REQ)) begin
            v_idx = v_idx - 4'(N_REQ);
         end else begin
            v_idx = v_idx;
         end
         for (int j = 0; j < N_REQ; j++) begin
            if (!w_found && (v_idx == 4'(j)) && req_valid[j]) begin
               w_found = 1'b1;
               w_sel   = 3'(j);
            end else begin
               w_found = w_found;
            end
         end
      end
   end

   // Select the granted requester's inputs and build its one-hot ready mask.
   always_comb begin
      w_g_valid = 1'b0;
      w_g_data  = 64'd0;
      w_g_bits  = 7'd0;
      w_g_last  = 1'b0;
      w_gnt_oh  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant == 3'(i)) begin
            w_g_valid   = req_valid[i];
            w_g_data    = req_data[i*64 +: 64];
            w_g_bits    = req_bits[i*7 +: 7];
            w_g_last    = req_last[i];
            w_gnt_oh[i] = 1'b1;
         end else begin
            w_gnt_oh[i] = 1'b0;
         end
      end
   end

   // Next pointer after the current message, and flush-exit conditions.
   always_comb begin
      if (r_grant >= 3'(N_REQ - 1)) begin
         w_ptr_nxt = 3'd0;
      end else begin
         w_ptr_nxt = r_grant + 3'd1;
      end
      // Nothing was packed and no fin strobe went out: the zero-bit fin strobe
      // closes the message on its own, no flush completion will follow.
      w_flush_imm = !r_fin_sent && (r_fill == 6'd0);
      w_flush_end = w_flush_imm || sc_done || (r_to_cnt == TO_LAST);
   end

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= 3'd0;
         r_grant    <= 3'd0;
         r_fill     <= 6'd0;
         r_gap_cnt  <= 4'd0;
         r_to_cnt   <= 8'd0;
         r_last     <= 1'b0;
         r_fin_sent <= 1'b0;
         r_ready    <= '0;
         r_data     <= 64'd0;
         r_vb       <= 7'd0;
         r_dv       <= 1'b0;
         r_fin      <= 1'b0;
         r_busy     <= 1'b0;
         r_err_len  <= 1'b0;
         r_err_to   <= 1'b0;
`ifdef CONCAT_STATS_EN
         r_stats_frags <= 32'd0;
         r_stats_msgs  <= 16'd0;
`endif
      end else begin
         // Strobe and accept outputs are single-cycle pulses; data is zeroed when idle.
         r_ready <= '0;
         r_dv    <= 1'b0;
         r_fin   <= 1'b0;
         r_data  <= 64'd0;
         r_vb    <= 7'd0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant    <= w_sel;
                  r_state    <= S_ISSUE;
                  r_busy     <= 1'b1;
                  r_last     <= 1'b0;
                  r_fin_sent <= 1'b0;
                  r_to_cnt   <= 8'd0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ISSUE: begin
               // The ready pulse from the previous cycle must be seen by the
               // requester before its next fragment is taken.
               if (w_g_valid && (r_ready == '0)) begin
                  r_ready <= w_gnt_oh;
                  if (w_g_bits > 7'd64) begin
                     r_err_len <= 1'b1;
                     if (w_g_last) begin
                        r_state  <= S_FLUSH;
                        r_to_cnt <= 8'd0;
                     end else begin
                        r_state <= S_ISSUE;
                     end
                  end else if (w_g_bits == 7'd0) begin
                     if (w_g_last) begin
                        r_state  <= S_FLUSH;
                        r_to_cnt <= 8'd0;
                     end else begin
                        r_state <= S_ISSUE;
                     end
                  end else begin
                     r_data     <= w_g_data;
                     r_vb       <= w_g_bits;
                     r_dv       <= 1'b1;
                     r_fin      <= w_g_last;
                     r_fill     <= r_fill + w_g_bits[5:0];
                     r_last     <= w_g_last;
                     r_fin_sent <= w_g_last;
                     r_gap_cnt  <= GAP_LOAD;
                     r_state    <= S_GAP;
`ifdef CONCAT_STATS_EN
                     r_stats_frags <= r_stats_frags + 32'd1;
`endif
                  end
               end else begin
                  r_state <= S_ISSUE;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == 4'd0) begin
                  if (r_last) begin
                     r_state  <= S_FLUSH;
                     r_to_cnt <= 8'd0;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt - 4'd1;
               end
            end
            S_FLUSH: begin
               // A message whose closing fragment carried no bits still needs
               // a fin marker, sent as a zero-bit strobe.
               if (!r_fin_sent) begin
                  r_dv       <= 1'b1;
                  r_fin      <= 1'b1;
                  r_fin_sent <= 1'b1;
`ifdef CONCAT_STATS_EN
                  r_stats_frags <= r_stats_frags + 32'd1;
`endif
               end else begin
                  r_fin_sent <= r_fin_sent;
               end
               if (w_flush_end) begin
                  if (!w_flush_imm && !sc_done) begin
                     r_err_to <= 1'b1;
                  end else begin
                     r_err_to <= r_err_to;
                  end
                  r_fill   <= 6'd0;
                  r_ptr    <= w_ptr_nxt;
                  r_to_cnt <= 8'd0;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
`ifdef CONCAT_STATS_EN
                  r_stats_msgs <= r_stats_msgs + 16'd1;
`endif
               end else begin
                  r_to_cnt <= r_to_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_concat_stream_sched.sv
// ---------------------------------------------------------------------------
// tb_concat_stream_sched
//
// Directed bench for concat_stream_sched. Expected strobes are queued when a
// fragment is presented and compared by a negedge monitor when the DUT
// strobes; control/status outputs are checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_concat_stream_sched;

   localparam int N_REQ        = 2;
   localparam int MIN_GAP      = 2;
   localparam int DONE_TIMEOUT = 255;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [N_REQ-1:0]     req_valid;
   logic [64*N_REQ-1:0]  req_data;
   logic [7*N_REQ-1:0]   req_bits;
   logic [N_REQ-1:0]     req_last;
   logic [N_REQ-1:0]     req_ready;
   logic [63:0]          sc_data_in;
   logic [6:0]           sc_valid_bits;
   logic                 sc_data_valid;
   logic                 sc_msg_fin;
   logic                 sc_done;
   logic [2:0]           grant_id;
   logic                 busy;
   logic [5:0]           fill_bits;
   logic                 err_len;
   logic                 err_timeout;
`ifdef CONCAT_STATS_EN
   logic [31:0]          stats_frags;
   logic [15:0]          stats_msgs;
`endif

   typedef struct packed {
      logic [63:0] d;
      logic [6:0]  b;
      logic        fin;
      logic [5:0]  fill;
      logic [2:0]  g;
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   logic [5:0]  exp_fill;
   int          checks   = 0;
   int          failures = 0;
   int          idle_cnt = 0;
   bit          seen_strobe = 1'b0;

   concat_stream_sched #(
      .N_REQ        (N_REQ),
      .MIN_GAP      (MIN_GAP),
      .DONE_TIMEOUT (DONE_TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_bits      (req_bits),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .sc_data_in    (sc_data_in),
      .sc_valid_bits (sc_valid_bits),
      .sc_data_valid (sc_data_valid),
      .sc_msg_fin    (sc_msg_fin),
      .sc_done       (sc_done),
      .grant_id      (grant_id),
      .busy          (busy),
      .fill_bits     (fill_bits),
      .err_len       (err_len),
      .err_timeout   (err_timeout)
`ifdef CONCAT_STATS_EN
      ,
      .stats_frags   (stats_frags),
      .stats_msgs    (stats_msgs)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_sc_data_in"}, sc_data_in, 64'd0);
      chk({tag, "_sc_valid_bits"}, 64'(sc_valid_bits), 64'd0);
      chk({tag, "_sc_data_valid"}, 64'(sc_data_valid), 64'd0);
      chk({tag, "_sc_msg_fin"}, 64'(sc_msg_fin), 64'd0);
      chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_fill_bits"}, 64'(fill_bits), 64'd0);
      chk({tag, "_err_len"}, 64'(err_len), 64'd0);
      chk({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
   endtask

   task automatic present(input int idx, input logic [63:0] d, input logic [6:0] b, input logic l);
      req_data[idx*64 +: 64] = d;
      req_bits[idx*7 +: 7]   = b;
      req_last[idx]          = l;
      req_valid[idx]         = 1'b1;
   endtask

   task automatic expect_frag(input logic [63:0] d, input logic [6:0] b, input logic l, input logic [2:0] g);
      exp_t e;
      exp_fill = exp_fill + b[5:0];
      e.d    = d;
      e.b    = b;
      e.fin  = l;
      e.fill = exp_fill;
      e.g    = g;
      q.push_back(e);
   endtask

   task automatic wait_ready(input int idx);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready[idx]) begin
            seen = 1'b1;
            break;
         end
      end
      req_valid[idx] = 1'b0;
      chk($sformatf("req_ready%0d_seen", idx), 64'(seen), 64'd1);
   endtask

   task automatic send(input int idx, input logic [63:0] d, input logic [6:0] b, input logic l,
                       input bit strobes);
      if (strobes) expect_frag(d, b, l, 3'(idx));
      present(idx, d, b, l);
      wait_ready(idx);
   endtask

   task automatic done_pulse();
      @(negedge clk);
      sc_done = 1'b1;
      @(negedge clk);
      sc_done = 1'b0;
   endtask

   // Strobe scoreboard, gap spacing and ready ownership monitor.
   always @(negedge clk) begin
      if (!rst) begin
         seen_strobe = 1'b0;
         idle_cnt    = 0;
      end else if (sc_data_valid) begin
         chk("strobe_expected", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("sc_data_in", sc_data_in, m_e.d);
            chk("sc_valid_bits", 64'(sc_valid_bits), 64'(m_e.b));
            chk("sc_msg_fin", 64'(sc_msg_fin), 64'(m_e.fin));
            chk("fill_bits", 64'(fill_bits), 64'(m_e.fill));
            chk("grant_at_strobe", 64'(grant_id), 64'(m_e.g));
         end
         if (seen_strobe) chk("min_gap", 64'(idle_cnt >= MIN_GAP), 64'd1);
         seen_strobe = 1'b1;
         idle_cnt    = 0;
      end else begin
         idle_cnt++;
      end
      if (rst && (req_ready != '0)) begin
         chk("ready_owner", 64'(req_ready), 64'(N_REQ'(1) << grant_id));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      req_bits  = '0;
      sc_done   = 1'b0;
      exp_fill  = 6'd0;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // Four-fragment message from requester 0.
      send(0, 64'h000abcdef1234567, 7'd52, 1'b0, 1'b1);
      send(0, 64'he,                7'd4,  1'b0, 1'b1);
      send(0, 64'hebf3,             7'd16, 1'b0, 1'b1);
      send(0, 64'hec,               7'd8,  1'b1, 1'b1);
      repeat (4) @(negedge clk);
      chk("s1_busy_in_flush", 64'(busy), 64'd1);
      chk("s1_fill_in_flush", 64'(fill_bits), 64'd16);
      done_pulse();
      exp_fill = 6'd0;
      chk("s1_idle_after_done", 64'(busy), 64'd0);
      chk("s1_fill_after_done", 64'(fill_bits), 64'd0);
      chk("s1_queue_empty", 64'(q.size()), 64'd0);
`ifdef CONCAT_STATS_EN
      chk("s1_stats_frags", 64'(stats_frags), 64'd4);
      chk("s1_stats_msgs", 64'(stats_msgs), 64'd1);
`endif
      // Pointer has moved to 1: contention now favours requester 1.
      present(1, 64'h1, 7'd3, 1'b1);
      present(0, 64'h2, 7'd3, 1'b1);
      @(negedge clk);
      chk("s1_pointer_grant", 64'(grant_id), 64'd1);
      chk("s1_pointer_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      check_zero("async_reset");

      // Both requesters valid from reset.
      q.delete();
      exp_fill = 6'd0;
      req_valid = '0;
      present(1, 64'h22, 7'd12, 1'b1);
      present(0, 64'h11, 7'd10, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      send(0, 64'h11, 7'd10, 1'b0, 1'b1);
      send(0, 64'h33, 7'd6,  1'b1, 1'b1);
      repeat (4) @(negedge clk);
      chk("s2_grant_held0", 64'(grant_id), 64'd0);
      chk("s2_req1_waiting", 64'(req_valid[1]), 64'd1);
      exp_fill = 6'd0;
      expect_frag(64'h22, 7'd12, 1'b1, 3'd1);
      done_pulse();
      wait_ready(1);
      chk("s2_grant1", 64'(grant_id), 64'd1);
      present(0, 64'h44, 7'd8, 1'b1);
      present(1, 64'h55, 7'd9, 1'b1);
      repeat (4) @(negedge clk);
      chk("s2_grant_held1", 64'(grant_id), 64'd1);
      exp_fill = 6'd0;
      expect_frag(64'h44, 7'd8, 1'b1, 3'd0);
      done_pulse();
      wait_ready(0);
      req_valid[1] = 1'b0;
      chk("s2_grant_back0", 64'(grant_id), 64'd0);
      repeat (4) @(negedge clk);
      done_pulse();
      exp_fill = 6'd0;
      chk("s2_idle", 64'(busy), 64'd0);

      // Oversized and empty fragments inside a message.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("s3_reset");
      @(negedge clk);
      rst = 1'b1;
      send(0, 64'h0f0f0, 7'd20, 1'b0, 1'b1);
      send(0, 64'hdead,  7'd70, 1'b0, 1'b0);
      chk("s3_err_len_set", 64'(err_len), 64'd1);
      chk("s3_fill_after_drop", 64'(fill_bits), 64'd20);
      send(0, 64'h0,     7'd0,  1'b0, 1'b0);
      chk("s3_fill_after_empty", 64'(fill_bits), 64'd20);
      send(0, 64'h3ff,   7'd10, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      done_pulse();
      exp_fill = 6'd0;
      chk("s3_err_len_sticky", 64'(err_len), 64'd1);
      chk("s3_idle", 64'(busy), 64'd0);

      // Reset between strobes 2 and 3 of requester 1's message.
      send(1, 64'h7, 7'd3, 1'b0, 1'b1);
      send(1, 64'h8, 7'd4, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_zero("s5_mid_reset");
      chk("s5_queue_empty", 64'(q.size()), 64'd0);
      present(1, 64'h9, 7'd5, 1'b1);
      present(0, 64'ha, 7'd6, 1'b1);
      exp_fill = 6'd0;
      expect_frag(64'ha, 7'd6, 1'b1, 3'd0);
      @(negedge clk);
      rst = 1'b1;
      wait_ready(0);
      req_valid[1] = 1'b0;
      chk("s5_grant0", 64'(grant_id), 64'd0);
      repeat (4) @(negedge clk);
      done_pulse();
      exp_fill = 6'd0;

      // Flush completion withheld.
      send(1, 64'h1f, 7'd5, 1'b1, 1'b1);
      repeat (MIN_GAP + DONE_TIMEOUT - 1) @(negedge clk);
      chk("s4_no_timeout_yet", 64'(err_timeout), 64'd0);
      chk("s4_busy_before", 64'(busy), 64'd1);
      @(negedge clk);
      chk("s4_timeout", 64'(err_timeout), 64'd1);
      chk("s4_idle", 64'(busy), 64'd0);
      chk("s4_fill_cleared", 64'(fill_bits), 64'd0);
      repeat (3) @(negedge clk);
      chk("s4_timeout_sticky", 64'(err_timeout), 64'd1);
      chk("final_queue_empty", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/concat_stream_sched.md
Name: concat_stream_sched

Overview:
- Message-level scheduler that shares one shift_concat packer between N_REQ codeword sources, e.g. the compressor codeword path and the header/trailer generator.
- Arbitrates round-robin per message and locks the grant until that requester's last fragment is packed.
- Drives shift_concat data_in, valid_bits, data_valid and msg_fin with the required pulse spacing.
- Tracks fill level modulo 64 and waits for the final flush done before re-arbitrating.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- MIN_GAP, 1, idle cycles forced between consecutive data_valid pulses (1..15).
- DONE_TIMEOUT, 255, cycles to wait for flush done before flagging an error (8-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i has a fragment presented.
- req_data  in  64*N_REQ  fragment i, right-aligned, slice [64i+63:64i].
- req_bits  in  7*N_REQ  valid bit count of fragment i (0..64).
- req_last  in  N_REQ  fragment i is the last of its message.
- req_ready  out  N_REQ  one-cycle accept pulse to requester i.
- sc_data_in  out  64  to shift_concat data_in.
- sc_valid_bits  out  7  to shift_concat valid_bits.
- sc_data_valid  out  1  one-cycle fragment strobe.
- sc_msg_fin  out  1  end-of-message flag, qualified by sc_data_valid.
- sc_done  in  1  shift_concat word-complete / flush-complete pulse.
- grant_id  out  3  index of the locked requester.
- busy  out  1  high outside IDLE.
- fill_bits  out  6  bits pending in the packer, modulo 64.
- err_len  out  1  sticky: a fragment with req_bits > 64 was seen.
- err_timeout  out  1  sticky: flush done missed.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, round-robin pointer=0, fill=0, gap counter=0, timeout counter=0.
- IDLE:
  - If any req_valid, grant the first requester at or after the pointer (wrapping); set grant_id.
  - Go to ISSUE next cycle; no grant change occurs mid-message.
- ISSUE, granted req_valid high:
  - Latch the fragment; pulse req_ready[grant] for one cycle.
  - If 1 <= req_bits <= 64: in the same cycle drive sc_data_in, sc_valid_bits and sc_data_valid=1; set sc_msg_fin=req_last.
  - fill <= (fill + bits) mod 64.
  - Latency from request valid to strobe: 1 cycle in ISSUE.
- ISSUE, req_bits = 0: accept (ready pulse), no strobe, fill unchanged.
- ISSUE, req_bits > 64: accept, drop the fragment, set err_len, no strobe. If req_last is set, still go to FLUSH.
- After a strobe: go to GAP and hold all sc_* low for MIN_GAP cycles.
  - Return to ISSUE if the fragment was not last, else FLUSH.
  - A last fragment dropped or with 0 bits goes directly to FLUSH.
- ISSUE, granted req_valid low: wait in ISSUE with the grant held.
- FLUSH, fill = 0 and no strobe issued with msg_fin: return to IDLE immediately, with a zero-bit strobe with sc_msg_fin=1 sent first.
- FLUSH, otherwise: wait for sc_done with timeout counting.
  - On sc_done: fill <= 0, advance the pointer to grant+1 mod N_REQ, go to IDLE.
  - On timeout (DONE_TIMEOUT cycles): set err_timeout, fill <= 0, advance the pointer, go to IDLE.
- sc_done outside FLUSH is a mid-message word completion and is ignored for control. fill already accounts for it by the mod-64 wrap.
- sc_done arriving in the same cycle FLUSH is entered is honoured.
- Only the granted requester ever sees req_ready; the others are held off until IDLE.
- Reset mid-message drops all state; err flags clear only on reset.

Optional Feature:
- Macro: CONCAT_STATS_EN.
- Defined: adds outputs stats_frags (32-bit count of strobes issued) and stats_msgs (16-bit count of completed messages, including timeouts). Both clear on reset and wrap at their maximum.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Req0 sends 52, 4, 16 and last 8 bits (data 64'h000abcdef1234567, 64'he, 64'hebf3, 64'hec) -> four strobes, each followed by MIN_GAP idle cycles; fill 52, 56, 8, 16; msg_fin only on the 4th strobe; return to IDLE on sc_done; grant pointer = 1.
- Req0 and req1 valid together from reset -> req0 granted first; req1 gets req_ready only after req0's flush sc_done; next contention grants req0 again only after req1's message.
- Fragment with req_bits=70 mid-message -> req_ready pulse, no sc_data_valid, err_len=1 and stays 1; following fragments continue normally.
- Last fragment sent and sc_done withheld -> err_timeout=1 exactly DONE_TIMEOUT cycles after FLUSH entry; FSM IDLE; fill=0.
- rst pulled low between strobes 2 and 3 -> all outputs 0 asynchronously; after release, the next request is granted from requester 0 with fill=0.
- With CONCAT_STATS_EN, run the first scenario twice -> stats_frags=8, stats_msgs=2.
